systolic_skew_feeder: RTL and testbench

Upstream stage of the systolic matrix multiplier. It latches two DIM x DIM operand matrices, A (rows) and B (columns). It then drives them into the array's west_i/north_i edges as diagonally skewed wavefronts, one step per clock, and asserts the array's start_bit. It holds start_bit until the array reports done_o, then returns to idle and accepts the next matrix pair.

---
 rtl/systolic_skew_feeder.sv | 174 +++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
// Front end of the systolic matrix multiplier. It latches a DIM x DIM operand
// pair (A by rows, B by columns) and streams it into the array's west and
// north edges as diagonally skewed wavefronts, one diagonal per clock. It
// holds start_bit_o until the array reports done, then goes idle again.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      request, accepted only while ready_o=1
//   a_i, b_i     operand matrices, element [r][c] at (r*DIM+c)*DATA_WIDTH
//   done_i       done_o from the array
//   west_o       west edge lanes, lane i at i*DATA_WIDTH
//   north_o      north edge lanes, lane j at j*DATA_WIDTH
//   start_bit_o  start_bit to the array
//   ready_o      idle, can accept start_i
//   busy_o       inverse of ready_o
module systolic_skew_feeder #(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNTBITS    = 4
) (
    input  logic                                                              clk_i,
    input  logic                                                              rst_ni,
    input  logic                                                              start_i,
    input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0] a_i,
    input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0] b_i,
    input  logic                                                              done_i,
    output logic [(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0]                      west_o,
    output logic [(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0]                      north_o,
    output logic                                                              start_bit_o,
    output logic                                                              ready_o,
    output logic                                                              busy_o
);

    localparam int unsigned DIM       = BUS_WIDTH / DATA_WIDTH;
    localparam int unsigned MAT_W     = DIM * DIM * DATA_WIDTH;
    localparam int unsigned LANE_W    = DIM * DATA_WIDTH;
    localparam int unsigned LAST_STEP = 2 * DIM - 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FEED = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]         state_q,     state_d;
    logic [CNTBITS-1:0] cnt_q,       cnt_d;
    logic [MAT_W-1:0]   a_q,         a_d;
    logic [MAT_W-1:0]   b_q,         b_d;
    logic [LANE_W-1:0]  west_q,      west_d;
    logic [LANE_W-1:0]  north_q,     north_d;
    logic               start_bit_q, start_bit_d;
    logic               ready_q,     ready_d;
    logic               busy_q,      busy_d;

    // West wavefront at step t: lane i carries A[i][t-i] while that column exists.
    function automatic logic [LANE_W-1:0] west_step(input logic [MAT_W-1:0] m,
                                                    input int unsigned       t);
        logic [LANE_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DIM; i++) begin
            if ((t >= i) && ((t - i) < DIM)) begin
                v[i*DATA_WIDTH +: DATA_WIDTH] = m[(i*DIM + (t - i))*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return v;
    endfunction

    // North wavefront at step t: lane j carries B[t-j][j] while that row exists.
    function automatic logic [LANE_W-1:0] north_step(input logic [MAT_W-1:0] m,
                                                     input int unsigned       t);
        logic [LANE_W-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < DIM; j++) begin
            if ((t >= j) && ((t - j) < DIM)) begin
                v[j*DATA_WIDTH +: DATA_WIDTH] = m[((t - j)*DIM + j)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return v;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            west_q      <= '0;
            north_q     <= '0;
            start_bit_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            west_q      <= west_d;
            north_q     <= north_d;
            start_bit_q <= start_bit_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        west_d      = west_q;
        north_d     = north_q;
        start_bit_d = start_bit_q;
        ready_d     = ready_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    // Step 0 comes straight from the inputs so it is visible
                    // in the first cycle after acceptance.
                    a_d         = a_i;
                    b_d         = b_i;
                    west_d      = west_step(a_i, 0);
                    north_d     = north_step(b_i, 0);
                    cnt_d       = CNTBITS'(1);
                    start_bit_d = 1'b1;
                    ready_d     = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_FEED;
                end
            end
            ST_FEED: begin
                // cnt_q holds the step to present at this edge; once it passes
                // the last diagonal it parks at 2*DIM-1.
                if (32'(cnt_q) <= LAST_STEP) begin
                    west_d  = west_step(a_q, 32'(cnt_q));
                    north_d = north_step(b_q, 32'(cnt_q));
                    cnt_d   = cnt_q + CNTBITS'(1);
                end else begin
                    west_d  = '0;
                    north_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                west_d  = '0;
                north_d = '0;
                if (done_i) begin
                    start_bit_d = 1'b0;
                    ready_d     = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                west_d      = '0;
                north_d     = '0;
                start_bit_d = 1'b0;
                ready_d     = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign west_o      = west_q;
    assign north_o     = north_q;
    assign start_bit_o = start_bit_q;
    assign ready_o     = ready_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with DIM=4, DATA_WIDTH=8.
module tb_systolic_skew_feeder;

    logic         clk_i;
    logic         rst_ni;
    logic         start_i;
    logic [127:0] a_i;
    logic [127:0] b_i;
    logic         done_i;
    logic [31:0]  west_o;
    logic [31:0]  north_o;
    logic         start_bit_o;
    logic         ready_o;
    logic         busy_o;

    int n_cmp;
    int n_err;

    logic [127:0] a_ref;
    logic [127:0] b_ref;
    logic [31:0]  exp_w [8];
    logic [31:0]  exp_n [8];
    logic [66:0]  got;
    logic [66:0]  req;

    systolic_skew_feeder #(
        .BUS_WIDTH (32),
        .DATA_WIDTH(8),
        .CNTBITS   (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .done_i     (done_i),
        .west_o     (west_o),
        .north_o    (north_o),
        .start_bit_o(start_bit_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive start_i for exactly one rising edge.
    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    // Finish a run already sitting in WAIT.
    task automatic pulse_done();
        @(negedge clk_i);
        done_i = 1'b1;
        @(posedge clk_i);
        #1 done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        got = {west_o, north_o, start_bit_o, ready_o, busy_o};
        req = {32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL reset_in_hold got=%h req=%h", got, req);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        got = {west_o, north_o, start_bit_o, ready_o, busy_o};
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL reset_after_release got=%h req=%h", got, req);
        end

        // Abort mid-feed between edges.
        pulse_start();
        @(negedge clk_i);
        @(negedge clk_i);
        got = {west_o, north_o, start_bit_o, ready_o, busy_o};
        req = {exp_w[1], exp_n[1], 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL reset_prefeed_step1 got=%h req=%h", got, req);
        end
        #2 rst_ni = 1'b0;
        #1;
        got = {west_o, north_o, start_bit_o, ready_o, busy_o};
        req = {32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL reset_async_abort got=%h req=%h", got, req);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            got = {west_o, north_o, start_bit_o, ready_o, busy_o};
            n_cmp++;
            if (got !== req) begin
                n_err++;
                $display("FAIL reset_no_residual[%0d] got=%h req=%h", k, got, req);
            end
        end
    endtask

    task automatic test_skew_and_handshake();
        pulse_start();
        for (int t = 0; t < 8; t++) begin
            @(negedge clk_i);
            got = {west_o, north_o, start_bit_o, ready_o, busy_o};
            req = {exp_w[t], exp_n[t], 1'b1, 1'b0, 1'b1};
            n_cmp++;
            if (got !== req) begin
                n_err++;
                $display("FAIL skew_step%0d got=%h req=%h", t, got, req);
            end
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            got = {west_o, north_o, start_bit_o, ready_o, busy_o};
            req = {32'h0, 32'h0, 1'b1, 1'b0, 1'b1};
            n_cmp++;
            if (got !== req) begin
                n_err++;
                $display("FAIL wait_hold[%0d] got=%h req=%h", k, got, req);
            end
        end
        pulse_done();
        @(negedge clk_i);
        got = {west_o, north_o, start_bit_o, ready_o, busy_o};
        req = {32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL done_to_idle got=%h req=%h", got, req);
        end
    endtask

    task automatic test_busy_reject();
        pulse_start();
        for (int t = 0; t < 8; t++) begin
            @(negedge clk_i);
            got = {west_o, north_o, start_bit_o, ready_o, busy_o};
            req = {exp_w[t], exp_n[t], 1'b1, 1'b0, 1'b1};
            n_cmp++;
            if (got !== req) begin
                n_err++;
                $display("FAIL busy_step%0d got=%h req=%h", t, got, req);
            end
            if (t == 2) begin
                start_i = 1'b1;
                a_i     = ~a_ref;
                b_i     = ~b_ref;
            end else if (t == 3) begin
                start_i = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            got = {west_o, north_o, start_bit_o, ready_o, busy_o};
            req = {32'h0, 32'h0, 1'b1, 1'b0, 1'b1};
            n_cmp++;
            if (got !== req) begin
                n_err++;
                $display("FAIL busy_no_rerun[%0d] got=%h req=%h", k, got, req);
            end
        end
        a_i = a_ref;
        b_i = b_ref;
        pulse_done();
    endtask

    task automatic test_early_done();
        pulse_start();
        done_i = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk_i);
            got = {west_o, north_o, start_bit_o, ready_o, busy_o};
            req = {exp_w[t], exp_n[t], 1'b1, 1'b0, 1'b1};
            n_cmp++;
            if (got !== req) begin
                n_err++;
                $display("FAIL early_done_step%0d got=%h req=%h", t, got, req);
            end
        end
        // done_i still high: the first WAIT edge returns to idle.
        @(negedge clk_i);
        done_i = 1'b0;
        got = {west_o, north_o, start_bit_o, ready_o, busy_o};
        req = {32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL early_done_exit got=%h req=%h", got, req);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        repeat (9) @(negedge clk_i);
        got = {west_o, north_o, start_bit_o, ready_o, busy_o};
        req = {32'h0, 32'h0, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL b2b_in_wait got=%h req=%h", got, req);
        end
        done_i  = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i);
        #1 done_i = 1'b0;
        @(negedge clk_i);
        got = {west_o, north_o, start_bit_o, ready_o, busy_o};
        req = {32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL b2b_first_ignored got=%h req=%h", got, req);
        end
        @(posedge clk_i);
        #1 start_i = 1'b0;
        a_i = ~a_ref;
        b_i = ~b_ref;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk_i);
            got = {west_o, north_o, start_bit_o, ready_o, busy_o};
            req = {exp_w[t], exp_n[t], 1'b1, 1'b0, 1'b1};
            n_cmp++;
            if (got !== req) begin
                n_err++;
                $display("FAIL b2b_second_step%0d got=%h req=%h", t, got, req);
            end
        end
        a_i = a_ref;
        b_i = b_ref;
        pulse_done();
        @(negedge clk_i);
        got = {west_o, north_o, start_bit_o, ready_o, busy_o};
        req = {32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL b2b_final_idle got=%h req=%h", got, req);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        done_i  = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a_ref[(r*4+c)*8 +: 8] = 8'(10*r + c + 1);
                b_ref[(r*4+c)*8 +: 8] = 8'(50 + 10*r + c);
            end
        end
        a_i = a_ref;
        b_i = b_ref;

        // Hand-computed wavefronts, lane 3 leftmost.
        exp_w[0] = {8'd0,  8'd0,  8'd0,  8'd1};
        exp_n[0] = {8'd0,  8'd0,  8'd0,  8'd50};
        exp_w[1] = {8'd0,  8'd0,  8'd11, 8'd2};
        exp_n[1] = {8'd0,  8'd0,  8'd51, 8'd60};
        exp_w[2] = {8'd0,  8'd21, 8'd12, 8'd3};
        exp_n[2] = {8'd0,  8'd52, 8'd61, 8'd70};
        exp_w[3] = {8'd31, 8'd22, 8'd13, 8'd4};
        exp_n[3] = {8'd53, 8'd62, 8'd71, 8'd80};
        exp_w[4] = {8'd32, 8'd23, 8'd14, 8'd0};
        exp_n[4] = {8'd63, 8'd72, 8'd81, 8'd0};
        exp_w[5] = {8'd33, 8'd24, 8'd0,  8'd0};
        exp_n[5] = {8'd73, 8'd82, 8'd0,  8'd0};
        exp_w[6] = {8'd34, 8'd0,  8'd0,  8'd0};
        exp_n[6] = {8'd83, 8'd0,  8'd0,  8'd0};
        exp_w[7] = 32'h0;
        exp_n[7] = 32'h0;

        test_reset();
        test_skew_and_handshake();
        test_busy_reject();
        test_early_done();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
